// File: rtl/act_mem_arbiter_if.sv
// Activation memory arbiter bus: host port, engine read/write paths and the memory side.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface act_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              eng_rd_req;
  logic [ADDR_W-1:0] eng_rd_addr;
  logic              eng_rd_gnt;
  logic              eng_rvalid;
  logic [DATA_W-1:0] eng_rdata;

  logic              eng_wr_req;
  logic [ADDR_W-1:0] eng_wr_addr;
  logic [DATA_W-1:0] eng_wr_data;
  logic              eng_wr_gnt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  eng_rd_req, eng_rd_addr,
    input  eng_wr_req, eng_wr_addr, eng_wr_data,
    input  mem_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output eng_rd_gnt, eng_rvalid, eng_rdata,
    output eng_wr_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output eng_rd_req, eng_rd_addr,
    output eng_wr_req, eng_wr_addr, eng_wr_data,
    output mem_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  eng_rd_gnt, eng_rvalid, eng_rdata,
    input  eng_wr_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/act_mem_arbiter.sv
// Single-port activation memory arbiter: force_host > eng_wr > eng_rd > host, with host
// starvation protection and tagged read return. ACT_MEM_ARB_PERF_CNT_EN adds perf counters.
module act_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 64,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  act_mem_arbiter_if.slave    bus
`ifdef ACT_MEM_ARB_PERF_CNT_EN
  ,
  input  logic                perf_clear,
  output logic [31:0]         perf_conflicts,
  output logic [31:0]         perf_host_stall
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ENG_WR,
    SEL_ENG_RD,
    SEL_HOST
  } sel_t;

  sel_t             sel;
  logic [CNT_W-1:0] starve_cnt;
  logic             force_host;
  logic             host_denied;
  logic             rd_issue;
  logic [RD_LAT-1:0] rp_valid;
  logic [RD_LAT-1:0] rp_host;

  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      if (force_host && bus.host_req) sel = SEL_HOST;
      else if (bus.eng_wr_req)        sel = SEL_ENG_WR;
      else if (bus.eng_rd_req)        sel = SEL_ENG_RD;
      else if (bus.host_req)          sel = SEL_HOST;
    end
  end

  always_comb begin
    bus.host_gnt   = (sel == SEL_HOST);
    bus.eng_wr_gnt = (sel == SEL_ENG_WR);
    bus.eng_rd_gnt = (sel == SEL_ENG_RD);
    bus.mem_en     = (sel != SEL_NONE);
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (sel)
      SEL_ENG_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.eng_wr_addr;
        bus.mem_wdata = bus.eng_wr_data;
      end
      SEL_ENG_RD: begin
        bus.mem_addr  = bus.eng_rd_addr;
      end
      SEL_HOST: begin
        bus.mem_we    = bus.host_we;
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
      end
      default: ;
    endcase
  end

  assign host_denied = bus.host_req && (sel != SEL_HOST);
  assign rd_issue    = (sel == SEL_ENG_RD) || ((sel == SEL_HOST) && !bus.host_we);

  // force_host is set on the same edge the counter reaches the limit, so the grant
  // lands on the cycle right after the last permitted denial.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      force_host <= 1'b0;
    end else begin
      if (host_denied) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      if ((sel == SEL_HOST) || !bus.host_req) force_host <= 1'b0;
      else if (host_denied && (starve_cnt >= LIMIT_M1)) force_host <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp_valid <= '0;
      rp_host  <= '0;
    end else begin
      rp_valid[0] <= rd_issue;
      rp_host[0]  <= (sel == SEL_HOST);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rp_valid[i] <= rp_valid[i-1];
        rp_host[i]  <= rp_host[i-1];
      end
    end
  end

  assign bus.host_rvalid = rp_valid[RD_LAT-1] &&  rp_host[RD_LAT-1];
  assign bus.eng_rvalid  = rp_valid[RD_LAT-1] && !rp_host[RD_LAT-1];
  assign bus.host_rdata  = bus.mem_rdata;
  assign bus.eng_rdata   = bus.mem_rdata;

`ifdef ACT_MEM_ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = (bus.host_req && bus.eng_rd_req) || (bus.host_req && bus.eng_wr_req) ||
                    (bus.eng_rd_req && bus.eng_wr_req);

  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_conflicts  <= '0;
      perf_host_stall <= '0;
    end else begin
      if (conflict && (perf_conflicts != '1))     perf_conflicts  <= perf_conflicts + 1'b1;
      if (host_denied && (perf_host_stall != '1)) perf_host_stall <= perf_host_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_act_mem_arbiter.sv
// Bench for act_mem_arbiter: queue-based reference model checked every cycle plus directed
// literal checks; perf counter checks compile in with ACT_MEM_ARB_PERF_CNT_EN.
module tb_act_mem_arbiter;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 64;
  localparam int RD_LAT       = 2;
  localparam int STARVE_LIMIT = 8;

  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0010;
  localparam logic [63:0] D1 = 64'hCAFE_F00D_0000_0020;
  localparam logic [63:0] D2 = 64'h1234_5678_9ABC_0030;
  localparam logic [63:0] D3 = 64'h0F0F_A5A5_5A5A_0031;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  act_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ACT_MEM_ARB_PERF_CNT_EN
  logic        perf_clear;
  logic [31:0] perf_conflicts;
  logic [31:0] perf_host_stall;
`endif

  act_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ACT_MEM_ARB_PERF_CNT_EN
    ,
    .perf_clear(perf_clear),
    .perf_conflicts(perf_conflicts),
    .perf_host_stall(perf_host_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with RD_LAT read latency.
  logic [63:0] ram [0:255];
  logic [63:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    rd_pipe[0] <= ram[bus.mem_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who must win, and which reads come back when, with what data.
  typedef struct { int due; bit host; logic [63:0] data; } ret_t;
  ret_t        q[$];
  logic [63:0] mram [0:255];
  int          cyc = 0;
  int          denied = 0;

  always @(negedge clk) begin
    bit e_h, e_wr, e_rd, e_hv, e_ev;
    logic [63:0] e_data;
    logic [15:0] e_addr;
    logic [63:0] e_wdata;
    bit e_we;
    ret_t r;
    e_h = 0; e_wr = 0; e_rd = 0; e_hv = 0; e_ev = 0; e_data = '0;
    e_addr = '0; e_wdata = '0; e_we = 0;
    if (reset !== 1'b0) begin
    end else if (bus.host_req && (denied >= STARVE_LIMIT || !(bus.eng_wr_req || bus.eng_rd_req)))
      e_h = 1;
    else if (bus.eng_wr_req) e_wr = 1;
    else if (bus.eng_rd_req) e_rd = 1;
    if (e_h)  begin e_addr = bus.host_addr; e_we = bus.host_we; e_wdata = e_we ? bus.host_wdata : '0; end
    if (e_wr) begin e_addr = bus.eng_wr_addr; e_we = 1; e_wdata = bus.eng_wr_data; end
    if (e_rd) e_addr = bus.eng_rd_addr;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      e_data = r.data;
      if (r.host) e_hv = 1; else e_ev = 1;
    end
    chk("host_gnt",   bus.host_gnt,   e_h);
    chk("eng_wr_gnt", bus.eng_wr_gnt, e_wr);
    chk("eng_rd_gnt", bus.eng_rd_gnt, e_rd);
    chk("mem_en",     bus.mem_en,     e_h | e_wr | e_rd);
    chk("mem_we",     bus.mem_we,     e_we);
    if (e_h | e_wr | e_rd) chk("mem_addr", bus.mem_addr, e_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("host_rvalid", bus.host_rvalid, e_hv);
    chk("eng_rvalid",  bus.eng_rvalid,  e_ev);
    if (e_hv) chk("host_rdata", bus.host_rdata, e_data);
    if (e_ev) chk("eng_rdata",  bus.eng_rdata,  e_data);
    if (reset !== 1'b0) begin
      denied = 0;
      q.delete();
    end else begin
      if (bus.host_req && !e_h) denied++; else denied = 0;
      if (e_wr) mram[bus.eng_wr_addr[7:0]] = bus.eng_wr_data;
      if (e_h && bus.host_we) mram[bus.host_addr[7:0]] = bus.host_wdata;
      if (e_rd) q.push_back('{cyc + RD_LAT, 1'b0, mram[bus.eng_rd_addr[7:0]]});
      if (e_h && !bus.host_we) q.push_back('{cyc + RD_LAT, 1'b1, mram[bus.host_addr[7:0]]});
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.eng_rd_req = 0; bus.eng_rd_addr = '0;
    bus.eng_wr_req = 0; bus.eng_wr_addr = '0; bus.eng_wr_data = '0;
`ifdef ACT_MEM_ARB_PERF_CNT_EN
    perf_clear = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    look();
    chk("rst_host_rvalid", bus.host_rvalid, 0);
    chk("rst_eng_rvalid",  bus.eng_rvalid,  0);
    chk("rst_mem_en",      bus.mem_en,      0);
    step();
    reset = 1'b0;

    // Host write then read of 0x10.
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 16'h0010; bus.host_wdata = D0;
    look(); chk("t1_wr_gnt", bus.host_gnt, 1); chk("t1_wr_we", bus.mem_we, 1);
    step(); bus.host_we = 0;
    look(); chk("t1_rd_gnt", bus.host_gnt, 1); chk("t1_rd_we", bus.mem_we, 0);
    step(); bus.host_req = 0;
    look(); chk("t1_rvalid_early", bus.host_rvalid, 0);
    step();
    look(); chk("t1_rvalid", bus.host_rvalid, 1); chk("t1_rdata", bus.host_rdata, D0);
    step();

    // All three request together.
    bus.eng_wr_req = 1; bus.eng_wr_addr = 16'h0020; bus.eng_wr_data = D1;
    bus.eng_rd_req = 1; bus.eng_rd_addr = 16'h0010;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 16'h0020;
    look(); chk("t2_c0_wr", bus.eng_wr_gnt, 1); chk("t2_c0_rd", bus.eng_rd_gnt, 0);
    chk("t2_c0_host", bus.host_gnt, 0);
    step(); bus.eng_wr_req = 0;
    look(); chk("t2_c1_rd", bus.eng_rd_gnt, 1); chk("t2_c1_host", bus.host_gnt, 0);
    step(); bus.eng_rd_req = 0;
    look(); chk("t2_c2_host", bus.host_gnt, 1);
    step(); bus.host_req = 0;
    repeat (4) step();

    // Host starvation under continuous engine reads.
    bus.eng_rd_req = 1; bus.eng_rd_addr = 16'h0010;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 16'h0020;
    for (int i = 1; i <= STARVE_LIMIT; i++) begin
      look(); chk("t3_rd_gnt", bus.eng_rd_gnt, 1); chk("t3_host_denied", bus.host_gnt, 0);
      step();
    end
    look(); chk("t3_forced_host", bus.host_gnt, 1); chk("t3_rd_blocked", bus.eng_rd_gnt, 0);
    step(); bus.host_req = 0;
    look(); chk("t3_rd_resume", bus.eng_rd_gnt, 1);
    step(); bus.eng_rd_req = 0;
    repeat (4) step();

    // Back-to-back eng, host, eng reads.
    bus.eng_wr_req = 1; bus.eng_wr_addr = 16'h0030; bus.eng_wr_data = D2;
    step(); bus.eng_wr_addr = 16'h0031; bus.eng_wr_data = D3;
    step(); bus.eng_wr_req = 0; bus.eng_rd_req = 1; bus.eng_rd_addr = 16'h0030;
    step(); bus.eng_rd_req = 0; bus.host_req = 1; bus.host_we = 0; bus.host_addr = 16'h0031;
    step(); bus.host_req = 0; bus.eng_rd_req = 1; bus.eng_rd_addr = 16'h0020;
    look(); chk("t4_eng_rv0", bus.eng_rvalid, 1); chk("t4_eng_rd0", bus.eng_rdata, D2);
    chk("t4_host_rv0", bus.host_rvalid, 0);
    step(); bus.eng_rd_req = 0;
    look(); chk("t4_host_rv1", bus.host_rvalid, 1); chk("t4_host_rd1", bus.host_rdata, D3);
    chk("t4_eng_rv1", bus.eng_rvalid, 0);
    step();
    look(); chk("t4_eng_rv2", bus.eng_rvalid, 1); chk("t4_eng_rd2", bus.eng_rdata, D1);
    step();
    repeat (2) step();

    // Reset right after a read grant discards it.
    bus.eng_rd_req = 1; bus.eng_rd_addr = 16'h0010;
    look(); chk("t5_rd_gnt", bus.eng_rd_gnt, 1);
    step(); bus.eng_rd_req = 0; reset = 1;
    look(); chk("t5_rst_mem_en", bus.mem_en, 0);
    step(); reset = 0;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("t5_eng_rvalid", bus.eng_rvalid, 0); chk("t5_host_rvalid", bus.host_rvalid, 0);
      chk("t5_mem_en", bus.mem_en, 0); chk("t5_mem_we", bus.mem_we, 0);
      step();
    end

`ifdef ACT_MEM_ARB_PERF_CNT_EN
    perf_clear = 1;
    step(); perf_clear = 0;
    bus.eng_rd_req = 1; bus.eng_rd_addr = 16'h0010;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 16'h0020;
    repeat (4) step();
    step(); bus.eng_rd_req = 0; bus.host_req = 0;
    look(); chk("t6_conflicts", perf_conflicts, 5); chk("t6_host_stall", perf_host_stall, 5);
    step(); perf_clear = 1;
    step(); perf_clear = 0;
    look(); chk("t6_clr_conflicts", perf_conflicts, 0); chk("t6_clr_stall", perf_host_stall, 0);
    repeat (3) step();
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
